// File: rtl/nfu_fixed_pkg.sv
// Shared NFU fixed-point definitions: Q-format defaults, divider FSM
// encoding and sign-magnitude helpers (operate on words up to 32 bits).
package nfu_fixed_pkg;

   localparam int N_DEF = 16;
   localparam int Q_DEF = 10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIV,
      S_DONE
   } qdiv_state_t;

   // Magnitude field of an n-bit sign-magnitude word.
   function automatic logic [31:0] mag_of(
      input logic [31:0] x,
      input int          n
   );
      return x & ((32'd1 << (n - 1)) - 32'd1);
   endfunction

   // Largest magnitude representable in an n-bit word.
   function automatic logic [31:0] max_mag(input int n);
      return (32'd1 << (n - 1)) - 32'd1;
   endfunction

   // Sign bit to emit; a zero magnitude is always positive.
   function automatic logic sign_nz(
      input logic        s,
      input logic [31:0] mag
   );
      return s & (|mag);
   endfunction

endpackage

// File: rtl/qdiv_seq_if.sv
// Operand/result handshake bundle for qdiv_seq.
// master: producer+consumer side, slave: divider side.
interface qdiv_seq_if
   import nfu_fixed_pkg::*;
#(
   parameter int N = N_DEF
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a_in;
   logic [N-1:0] b_in;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] y_out;
   logic         ovf;
   logic         div_zero;

   modport master (
      output in_valid, a_in, b_in, out_ready,
      input  in_ready, out_valid, y_out, ovf, div_zero
   );

   modport slave (
      input  in_valid, a_in, b_in, out_ready,
      output in_ready, out_valid, y_out, ovf, div_zero
   );
endinterface

// File: rtl/qdiv_step.sv
// One restoring-division step. Ports: rem/d_bit/dvs in,
// rem_next/q_bit out. Requires rem < dvs on entry.
module qdiv_step #(
   parameter int N = 16
) (
   input  logic [N-1:0] rem,
   input  logic         d_bit,
   input  logic [N-2:0] dvs,
   output logic [N-1:0] rem_next,
   output logic         q_bit
);
   logic [N:0] cat;
   logic [N:0] diff;

   always_comb begin
      cat  = {rem, d_bit};
      diff = cat - {2'b00, dvs};
      // cat < 2*dvs, so the top bit of diff is a pure borrow flag
      q_bit    = ~diff[N];
      rem_next = q_bit ? diff[N-1:0] : cat[N-1:0];
   end
endmodule

// File: rtl/qdiv_seq.sv
// Iterative sign-magnitude Q-format divider with valid/ready on both sides.
// Ports: clk, rst_n (async low), bus (qdiv_seq_if.slave).
module qdiv_seq
   import nfu_fixed_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int Q = Q_DEF
) (
   input logic       clk,
   input logic       rst_n,
   qdiv_seq_if.slave bus
);
   localparam int ITER = N - 1 + Q;
   localparam int CW   = $clog2(ITER + 1);

   qdiv_state_t     state, nstate;
   logic [1:0]      rst_q;
   logic            rst_i;
   logic            sign_r;
   logic [ITER-1:0] dvd_r;
   logic [ITER-1:0] quo_r;
   logic [N-2:0]    dvs_r;
   logic [N-1:0]    rem_r;
   logic [CW-1:0]   cnt_r;
   logic [N-1:0]    y_r;
   logic            ovf_r;
   logic            dz_r;

   logic [N-2:0]    a_mag, b_mag, sat, mag_res;
   logic [N-1:0]    rem_next;
   logic            q_bit, last, accept, q_ovf;
   logic [ITER-1:0] q_full;
   logic            in_rdy, out_vld;

   // assert immediately, release two clocks later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_q <= 2'b00;
      else        rst_q <= {rst_q[0], 1'b1};
   end
   assign rst_i = rst_q[1];

   qdiv_step #(.N(N)) u_step (
      .rem      (rem_r),
      .d_bit    (dvd_r[ITER-1]),
      .dvs      (dvs_r),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_comb begin
      a_mag   = (N-1)'(mag_of(32'(bus.a_in), N));
      b_mag   = (N-1)'(mag_of(32'(bus.b_in), N));
      sat     = (N-1)'(max_mag(N));
      last    = (cnt_r == CW'(ITER - 1));
      accept  = bus.in_valid & in_rdy;
      q_full  = (quo_r << 1) | ITER'(q_bit);
      q_ovf   = ((q_full >> (N - 1)) != '0);
      mag_res = q_ovf ? sat : q_full[N-2:0];
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) state <= S_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate  = state;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      case (state)
         S_IDLE: begin
            in_rdy = 1'b1;
            if (bus.in_valid)
               nstate = (b_mag == '0) ? S_DONE : S_DIV;
         end
         S_DIV: begin
            if (last) nstate = S_DONE;
         end
         S_DONE: begin
            out_vld = 1'b1;
            if (bus.out_ready) nstate = S_IDLE;
         end
         default: nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         sign_r <= 1'b0;
         dvd_r  <= '0;
         quo_r  <= '0;
         dvs_r  <= '0;
         rem_r  <= '0;
         cnt_r  <= '0;
         y_r    <= '0;
         ovf_r  <= 1'b0;
         dz_r   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  sign_r <= bus.a_in[N-1] ^ bus.b_in[N-1];
                  dvd_r  <= ITER'(a_mag) << Q;
                  dvs_r  <= b_mag;
                  rem_r  <= '0;
                  quo_r  <= '0;
                  cnt_r  <= '0;
                  ovf_r  <= 1'b0;
                  dz_r   <= (b_mag == '0);
                  if (b_mag == '0) y_r <= {1'b0, sat};
               end
            end
            S_DIV: begin
               rem_r <= rem_next;
               dvd_r <= dvd_r << 1;
               quo_r <= q_full;
               cnt_r <= cnt_r + 1'b1;
               if (last) begin
                  y_r   <= {sign_nz(sign_r, 32'(mag_res)), mag_res};
                  ovf_r <= q_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;
   assign bus.y_out     = y_r;
   assign bus.ovf       = ovf_r;
   assign bus.div_zero  = dz_r;
endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
Iterative fixed-point divider, the inverse operation of the pipelined Q-format multiplier in the NFU datapath. It uses the same sign-magnitude format: MSB is the sign, the low N-1 bits are the magnitude, and Q of those bits are fractional. It serves normalisation and reciprocal paths where one result per ~N+Q cycles is sufficient. It uses a valid/ready handshake on both sides so it can sit between NFU stage buffers.

Parameters:
N, 16, total word width: sign bit plus N-1 magnitude bits.
Q, 10, number of fractional bits; must satisfy 0 <= Q < N-1.
ITER, N-1+Q (derived, localparam), restoring-division iterations per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operands a_in/b_in valid.
in_ready  output  1  block can accept an operation.
a_in  input  N  dividend, sign-magnitude Q(N-1-Q).Q.
b_in  input  N  divisor, same format.
out_valid  output  1  y_out and flags are valid.
out_ready  input  1  consumer accepts the result.
y_out  output  N  quotient, sign-magnitude, truncated toward zero.
ovf  output  1  quotient magnitude saturated; qualified by out_valid.
div_zero  output  1  divisor magnitude was zero; qualified by out_valid.

Behaviour:
- Reset (async assert, sync deassert inside the block): state IDLE, in_ready=1, out_valid=0, y_out=0, ovf=0, div_zero=0. All internal registers are cleared.
- Reset mid-operation: the operation is aborted silently and no result is produced.
- FSM states IDLE, DIV, DONE.
- IDLE:
  - in_ready=1.
  - Transfer occurs on in_valid&in_ready. On transfer the block latches:
    - sign = a[N-1]^b[N-1];
    - dividend = |a| << Q (ITER bits);
    - divisor = |b|;
    - remainder = 0;
    - iteration counter = 0.
  - If |b|==0, next state is DONE with y_out={1'b0,all ones}, div_zero=1, ovf=0.
  - Otherwise next state is DIV.
- DIV:
  - in_ready=0.
  - One restoring step per cycle, MSB first:
    - rem' = {rem, next dividend bit};
    - if rem' >= divisor, subtract and shift in 1;
    - else shift in 0.
  - The remainder register is N bits wide, which is enough to hold divisor-1 shifted by one.
  - After ITER steps, the next state is DONE.
- DONE entry (computed on the final DIV step):
  - Full quotient is ITER bits.
  - If any bit at position >= N-1 is set: magnitude = all ones (2^(N-1)-1) and ovf=1.
  - Otherwise magnitude = quotient[N-2:0] and ovf=0.
  - Sign bit = sign & (magnitude!=0). Negative zero is never emitted.
- DONE:
  - out_valid=1.
  - y_out, ovf and div_zero are held stable until out_valid&out_ready, then the next state is IDLE.
- No overlap: a new operation can be accepted no earlier than the cycle after the result handshake, so in_ready=0 throughout DONE.
- Latency, measured from the input handshake edge to out_valid high:
  - normal case: ITER+1 cycles, i.e. 26 at defaults;
  - divide-by-zero: 1 cycle.
- Throughput: one result per ITER+2 cycles minimum.
- a_in/b_in are sampled only at the transfer edge; later changes have no effect.
- Zero dividend: the result is 0x0000 with ovf=0, whatever the sign of the divisor.

Decomposition:
- Shared package nfu_fixed_pkg holds:
  - the N/Q defaults;
  - the state encoding (IDLE/DIV/DONE);
  - the sign-magnitude helpers: abs-magnitude extract, saturated max-magnitude constant, and sign-with-zero-clear.
- The multiplier and the divider both import this package.
- Sub-module qdiv_step: combinational single restoring step. Inputs are rem, dividend bit and divisor; outputs are rem_next and q_bit. It is instantiated once.

Test Plan:
- 3.0/2.0: a=0x0C00, b=0x0800 -> y=0x0600 (1.5), ovf=0, div_zero=0, out_valid exactly 26 cycles after the handshake.
- Signed and truncation: a=0x8C00 (-3.0), b=0x0800 -> y=0x8600. Also a=0x0400, b=0x0C00 -> y=0x0155 (341/1024, truncated).
- Divide-by-zero: a=0x0400, b=0x8000 (negative zero) -> y=0x7FFF, div_zero=1, ovf=0, out_valid 1 cycle after the handshake.
- Overflow: a=0x4000 (16.0), b=0x0001 -> y=0x7FFF, ovf=1. Also a=0x0000, b=0x8400 -> y=0x0000, not 0x8000.
- Backpressure: hold out_ready=0 for 10 cycles while in DONE -> y_out/ovf stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-DIV: assert rst_n=0 at iteration 12 -> outputs clear immediately (asynchronously). After release, a fresh 0x0C00/0x0800 operation completes correctly and no stale result is emitted.
